// File: rtl/epb_pkg.sv
// Shared constants and FSM encoding for the
// Wishbone-to-EPB bus initiator.
package epb_pkg;

  localparam int EPB_ADDR_LSB = 5;
  localparam int EPB_ADDR_MSB = 29;
  localparam int EPB_AW       = EPB_ADDR_MSB - EPB_ADDR_LSB + 1;
  localparam int EPB_DW       = 32;
  localparam int EPB_BEW      = EPB_DW / 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5,
    ST_RECOVER = 3'd6
  } epb_state_e;

  // Saturating increment used by the wait-for-RDY counter.
  function automatic int unsigned sat_inc(
    input int unsigned v,
    input int unsigned lim
  );
    return (v >= lim) ? lim : v + 1;
  endfunction

endpackage

// File: rtl/epb_sync_edge.sv
// Multi-flop synchroniser for an asynchronous EPB
// input plus a rising-edge pulse on the synced level.
module epb_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Shift the async input through the chain and keep
  // a delayed copy of the last stage for edge detect.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/wb_epb_master.sv
// Wishbone slave that runs one EPB initiator cycle
// per access: setup, CS_N strobe, wait RDY, recover.
module wb_epb_master
  import epb_pkg::*;
#(
  parameter int BUS_ADDR_WIDTH  = 32,
  parameter int BUS_DATA_WIDTH  = 32,
  parameter int SETUP_CYCLES    = 1,
  parameter int RECOVERY_CYCLES = 2,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [BUS_ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0] wbs_dat_i,
  output logic [BUS_DATA_WIDTH-1:0] wbs_dat_o,
  output logic                      wbs_ack_o,
  output logic                      wbs_err_o,
  output logic                      epb_cs_n_o,
  output logic                      epb_oe_n_o,
  output logic                      epb_r_w_n_o,
  output logic [3:0]                epb_be_n_o,
  output logic [5:29]               epb_addr_o,
  output logic [0:31]               epb_data_o,
  output logic                      epb_data_oe_n_o,
  input  logic [0:31]               epb_data_i,
  input  logic                      epb_rdy_i
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int RW = $clog2(RECOVERY_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    SU_END = 4'(SETUP_CYCLES - 1);
  localparam logic [RW-1:0] RC_END = RW'(RECOVERY_CYCLES - 1);

  epb_state_e state_q;

  logic                      cs_n_q;
  logic                      oe_n_q;
  logic                      r_w_n_q;
  logic [3:0]                be_n_q;
  logic [EPB_ADDR_LSB:EPB_ADDR_MSB] addr_q;
  logic [0:EPB_DW-1]         wdat_q;
  logic                      data_oe_n_q;
  logic [BUS_DATA_WIDTH-1:0] rdat_q;
  logic                      ack_q;
  logic                      err_q;
  logic                      abort_q;
  logic [3:0]                su_cnt_q;
  logic [RW-1:0]             rc_cnt_q;
  logic [TW-1:0]             to_cnt_q;
  logic [TW-1:0]             to_cnt_d;
  logic                      rdy_rise;
  logic                      to_hit;
  logic                      unused_adr;

  assign unused_adr = ^wbs_adr_i[BUS_ADDR_WIDTH-1:EPB_AW];

  epb_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_rdy_sync (
    .clk_i   (wb_clk_i),
    .rst_n_i (wb_rst_n_i),
    .d_i     (epb_rdy_i),
    .rise_o  (rdy_rise)
  );

  // Saturating wait counter and timeout compare on
  // its next value, so ERR lands TIMEOUT clocks after
  // WAIT entry.
  always_comb begin
    to_cnt_d = TW'(sat_inc(32'(to_cnt_q), 32'(TO_LIM)));
    to_hit   = (TIMEOUT_CYCLES != 0) && (to_cnt_d == TO_LIM);
  end

  // Bus-cycle sequencer with registered EPB and WB outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= ST_IDLE;
      cs_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      r_w_n_q     <= 1'b1;
      be_n_q      <= 4'hF;
      addr_q      <= '0;
      wdat_q      <= '0;
      data_oe_n_q <= 1'b1;
      rdat_q      <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      su_cnt_q    <= '0;
      rc_cnt_q    <= '0;
      to_cnt_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (!wbs_cyc_i) abort_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            addr_q      <= wbs_adr_i[EPB_AW-1:0];
            wdat_q      <= wbs_dat_i;
            be_n_q      <= ~wbs_sel_i;
            r_w_n_q     <= ~wbs_we_i;
            data_oe_n_q <= ~wbs_we_i;
            abort_q     <= 1'b0;
            su_cnt_q    <= '0;
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (su_cnt_q == SU_END) begin
            cs_n_q  <= 1'b0;
            oe_n_q  <= ~r_w_n_q;
            state_q <= ST_STROBE;
          end else begin
            su_cnt_q <= su_cnt_q + 4'd1;
          end
        end
        ST_STROBE: begin
          to_cnt_q <= '0;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rdy_rise) begin
            if (r_w_n_q) rdat_q <= epb_data_i;
            cs_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            data_oe_n_q <= 1'b1;
            ack_q       <= wbs_cyc_i & ~abort_q;
            state_q     <= ST_DONE;
          end else if (to_hit) begin
            cs_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            data_oe_n_q <= 1'b1;
            err_q       <= wbs_cyc_i & ~abort_q;
            state_q     <= ST_ERR;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        ST_DONE, ST_ERR: begin
          rc_cnt_q <= '0;
          state_q  <= ST_RECOVER;
        end
        ST_RECOVER: begin
          if (rc_cnt_q == RC_END) begin
            state_q <= ST_IDLE;
          end else begin
            rc_cnt_q <= rc_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wbs_dat_o       = rdat_q;
  assign wbs_ack_o       = ack_q;
  assign wbs_err_o       = err_q;
  assign epb_cs_n_o      = cs_n_q;
  assign epb_oe_n_o      = oe_n_q;
  assign epb_r_w_n_o     = r_w_n_q;
  assign epb_be_n_o      = be_n_q;
  assign epb_addr_o      = addr_q;
  assign epb_data_o      = wdat_q;
  assign epb_data_oe_n_o = data_oe_n_q;

endmodule

// File: tb/tb_wb_epb_master.sv
// Directed bench for wb_epb_master: writes, reads,
// timeout, held RDY, reset abort and cyc drop.
module tb_wb_epb_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        ack;
  logic        err;
  logic        cs_n;
  logic        oe_n;
  logic        r_w_n;
  logic [3:0]  be_n;
  logic [5:29] eaddr;
  logic [0:31] edata_o;
  logic        doe_n;
  logic [0:31] edata_i = '0;
  logic        rdy = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_epb_master #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .wb_clk_i        (clk),
    .wb_rst_n_i      (rst_n),
    .wbs_cyc_i       (cyc),
    .wbs_stb_i       (stb),
    .wbs_we_i        (we),
    .wbs_sel_i       (sel),
    .wbs_adr_i       (adr),
    .wbs_dat_i       (wdat),
    .wbs_dat_o       (rdat),
    .wbs_ack_o       (ack),
    .wbs_err_o       (err),
    .epb_cs_n_o      (cs_n),
    .epb_oe_n_o      (oe_n),
    .epb_r_w_n_o     (r_w_n),
    .epb_be_n_o      (be_n),
    .epb_addr_o      (eaddr),
    .epb_data_o      (edata_o),
    .epb_data_oe_n_o (doe_n),
    .epb_data_i      (edata_i),
    .epb_rdy_i       (rdy)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic wb_req(input logic w,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] s);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; wdat = d; sel = s;
  endtask

  task automatic wb_drop();
    cyc = 1'b0; stb = 1'b0;
  endtask

  // Wait for CS_N low; returns at that negedge.
  task automatic wait_cs_low(input string tag);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cs_n === 1'b0) begin
        ok = 1;
        break;
      end
    end
    check({tag, "_cs_low"}, 64'(ok), 64'd1);
  endtask

  // Clocks until ack or err, counting each.
  task automatic wait_end(input int max,
                          output int clks,
                          output int acks,
                          output int errs);
    clks = 0; acks = 0; errs = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      clks++;
      if (ack === 1'b1) acks++;
      if (err === 1'b1) errs++;
      if (ack === 1'b1 || err === 1'b1) break;
    end
  endtask

  int clks, acks, errs;

  initial begin
    // reset values
    #23;
    check("rst_cs_n",  64'(cs_n),    64'd1);
    check("rst_oe_n",  64'(oe_n),    64'd1);
    check("rst_r_w_n", 64'(r_w_n),   64'd1);
    check("rst_be_n",  64'(be_n),    64'hF);
    check("rst_addr",  64'(eaddr),   64'd0);
    check("rst_data",  64'(edata_o), 64'd0);
    check("rst_doe_n", 64'(doe_n),   64'd1);
    check("rst_rdat",  64'(rdat),    64'd0);
    check("rst_ack",   64'(ack),     64'd0);
    check("rst_err",   64'(err),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // write 0x10 <- DEADBEEF, rdy 4 clk after CS_N low
    wb_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    check("wr_setup_cs_n", 64'(cs_n), 64'd1);
    check("wr_setup_doe_n", 64'(doe_n), 64'd0);
    wait_cs_low("wr");
    check("wr_addr",  64'(eaddr),   64'h10);
    check("wr_data",  64'(edata_o), 64'hDEAD_BEEF);
    check("wr_doe_n", 64'(doe_n),   64'd0);
    check("wr_r_w_n", 64'(r_w_n),   64'd0);
    check("wr_be_n",  64'(be_n),    64'h0);
    check("wr_oe_n",  64'(oe_n),    64'd1);
    repeat (4) @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    check("wr_cs_wait", 64'(cs_n), 64'd0);
    wait_end(40, clks, acks, errs);
    check("wr_ack", 64'(acks), 64'd1);
    check("wr_err", 64'(errs), 64'd0);
    check("wr_cs_rel", 64'(cs_n), 64'd1);
    check("wr_doe_rel", 64'(doe_n), 64'd1);
    wb_drop();
    acks = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("wr_rec_cs%0d", i), 64'(cs_n), 64'd1);
      acks += int'(ack);
    end
    check("wr_one_ack", 64'(acks), 64'd0);

    // read 0x14, target drives 12345678
    edata_i = 32'h1234_5678;
    wb_req(1'b0, 32'h14, 32'h0, 4'hF);
    @(negedge clk);
    check("rd_setup_oe_n", 64'(oe_n), 64'd1);
    wait_cs_low("rd");
    check("rd_oe_n",  64'(oe_n),  64'd0);
    check("rd_r_w_n", 64'(r_w_n), 64'd1);
    check("rd_doe_n", 64'(doe_n), 64'd1);
    check("rd_addr",  64'(eaddr), 64'h14);
    repeat (2) @(negedge clk);
    check("rd_oe_wait", 64'(oe_n), 64'd0);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    wait_end(40, clks, acks, errs);
    check("rd_ack",  64'(acks), 64'd1);
    check("rd_dat",  64'(rdat), 64'h1234_5678);
    check("rd_oe_rel", 64'(oe_n), 64'd1);
    wb_drop();

    // timeout: no rdy, err 16 clk after WAIT entry
    edata_i = 32'hFFFF_0000;
    wb_req(1'b0, 32'h18, 32'h0, 4'hF);
    wait_cs_low("to");
    wait_end(40, clks, acks, errs);
    check("to_clks", 64'(clks), 64'd17);
    check("to_err",  64'(errs), 64'd1);
    check("to_ack",  64'(acks), 64'd0);
    check("to_cs_rel", 64'(cs_n), 64'd1);
    check("to_rdat", 64'(rdat), 64'h1234_5678);
    wb_drop();
    @(negedge clk);
    check("to_err_pulse", 64'(err), 64'd0);

    // rdy held high across two reads
    edata_i = 32'hA5A5_0001;
    wb_req(1'b0, 32'h20, 32'h0, 4'hF);
    wait_cs_low("hold1");
    rdy = 1'b1;
    wait_end(40, clks, acks, errs);
    check("hold1_ack", 64'(acks), 64'd1);
    check("hold1_dat", 64'(rdat), 64'hA5A5_0001);
    wb_drop();
    edata_i = 32'h0BAD_F00D;
    wb_req(1'b0, 32'h24, 32'h0, 4'hF);
    wait_cs_low("hold2");
    wait_end(40, clks, acks, errs);
    check("hold2_err",  64'(errs), 64'd1);
    check("hold2_ack",  64'(acks), 64'd0);
    check("hold2_clks", 64'(clks), 64'd17);
    check("hold2_dat",  64'(rdat), 64'hA5A5_0001);
    wb_drop();
    rdy = 1'b0;
    repeat (4) @(negedge clk);

    // reset asserted during WAIT
    wb_req(1'b1, 32'h30, 32'h5555_AAAA, 4'hF);
    wait_cs_low("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_cs_n",  64'(cs_n),  64'd1);
    check("rst_mid_be_n",  64'(be_n),  64'hF);
    check("rst_mid_doe_n", 64'(doe_n), 64'd1);
    wb_drop();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acks = 0; errs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      acks += int'(ack);
      errs += int'(err);
    end
    check("rst_no_ack", 64'(acks), 64'd0);
    check("rst_no_err", 64'(errs), 64'd0);
    check("rst_idle_cs", 64'(cs_n), 64'd1);

    // sel=0011 write, cyc dropped in WAIT
    wb_req(1'b1, 32'h40, 32'h0000_C0DE, 4'b0011);
    wait_cs_low("drop");
    check("drop_be_n", 64'(be_n), 64'b1100);
    @(negedge clk);
    wb_drop();
    @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    begin
      bit rel = 0;
      acks = 0; errs = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        acks += int'(ack);
        errs += int'(err);
        if (cs_n === 1'b1) begin
          rel = 1;
          break;
        end
      end
      repeat (4) begin
        @(negedge clk);
        acks += int'(ack);
        errs += int'(err);
      end
      check("drop_cs_rel", 64'(rel), 64'd1);
      check("drop_no_ack", 64'(acks), 64'd0);
      check("drop_no_err", 64'(errs), 64'd0);
    end

    // top address bits dropped, max word address
    wb_req(1'b1, 32'hFFFF_FFFC, 32'h8000_0001, 4'b1000);
    wait_cs_low("max");
    check("max_addr", 64'(eaddr), 64'h1FF_FFFC);
    check("max_data", 64'(edata_o), 64'h8000_0001);
    check("max_be_n", 64'(be_n), 64'b0111);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    wait_end(40, clks, acks, errs);
    check("max_ack", 64'(acks), 64'd1);
    wb_drop();
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
